// File: rtl/gmii_rx_frame_if.sv
// gmii_rx_frame_if: GMII receive bus plus the deframed payload stream and
// frame counters of gmii_rx_frame.
//   gmii_rx_dv/er/rxd : GMII receive side, driven by the PHY-facing stage
//   m_valid/m_data    : payload byte stream, no backpressure
//   m_first/m_last    : frame markers, qualified by m_valid
//   m_good/m_len      : frame status and payload length, valid with m_last
//   cnt_good/cnt_bad  : saturating frame counters
// Modports: master = PHY side (drives GMII, consumes stream),
//           slave  = deframer (consumes GMII, drives stream).
`timescale 1ns/1ps
interface gmii_rx_frame_if #(
  parameter int LEN_W = 11
);
  logic             gmii_rx_dv;
  logic             gmii_rx_er;
  logic [7:0]       gmii_rxd;
  logic             m_valid;
  logic [7:0]       m_data;
  logic             m_first;
  logic             m_last;
  logic             m_good;
  logic [LEN_W-1:0] m_len;
  logic [15:0]      cnt_good;
  logic [15:0]      cnt_bad;

  modport master (
    output gmii_rx_dv, gmii_rx_er, gmii_rxd,
    input  m_valid, m_data, m_first, m_last, m_good, m_len, cnt_good, cnt_bad
  );

  modport slave (
    input  gmii_rx_dv, gmii_rx_er, gmii_rxd,
    output m_valid, m_data, m_first, m_last, m_good, m_len, cnt_good, cnt_bad
  );
endinterface

// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: GMII receive deframer. Strips preamble/SFD, holds the last
// four bytes back so the FCS is never emitted, and streams payload bytes with
// first/last markers, frame status, payload length and good/bad counters.
// Ports:
//   clk : GMII rx clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : gmii_rx_frame_if.slave (GMII in, payload stream and counters out)
// Parameters: MIN_FRAME / MAX_FRAME legal frame bytes after SFD incl. FCS,
//   LEN_W width of m_len.
// Optional feature macro: GMII_RX_CRC_CHECK_EN adds the CRC-32 check on the
//   FCS; without it m_good depends on length and rx_er only.
`timescale 1ns/1ps
module gmii_rx_frame #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int LEN_W     = 11
) (
  input  logic           clk,
  input  logic           rst,
  gmii_rx_frame_if.slave bus
);

  localparam int N_W = $clog2(MAX_FRAME + 2);
  localparam logic [N_W-1:0] N_MIN  = N_W'(MIN_FRAME);
  localparam logic [N_W-1:0] N_MAX  = N_W'(MAX_FRAME);
  localparam logic [N_W-1:0] N_HOLD = N_W'(5);
  localparam logic [N_W-1:0] N_FCS  = N_W'(4);

  // state  | meaning
  // S_IDLE | waiting for the first preamble byte
  // S_PRE  | inside preamble, waiting for SFD
  // S_DATA | frame bytes after SFD, delay line running
  // S_DROP | discarding input until dv falls
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t           r_state;
  logic             r_dv;
  logic             r_er;
  logic [7:0]       r_rxd;
  logic             r_smp_ok;
  logic             r_armed;
  logic [N_W-1:0]   r_n;
  logic [4:0][7:0]  r_sr;
  logic             r_err;
  logic             r_valid;
  logic [7:0]       r_data;
  logic             r_first;
  logic             r_last;
  logic             r_good;
  logic [LEN_W-1:0] r_len;
  logic [15:0]      r_cnt_good;
  logic [15:0]      r_cnt_bad;
  logic             w_crc_ok;
  logic             w_end_good;

`ifdef GMII_RX_CRC_CHECK_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  assign w_crc_next = crc_byte(r_crc, r_rxd);
  // Running the CRC over the FCS as well leaves this fixed residue on a good frame.
  assign w_crc_ok   = (r_crc == 32'hDEBB20E3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= 32'hFFFFFFFF;
    end else if (r_state == S_PRE && r_dv && r_rxd == 8'hD5) begin
      r_crc <= 32'hFFFFFFFF;
    end else if (r_state == S_DATA && r_dv) begin
      r_crc <= w_crc_next;
    end
  end
`else
  assign w_crc_ok = 1'b1;
`endif

  assign w_end_good = (r_n >= N_MIN) && (r_n <= N_MAX) && !r_err && w_crc_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dv       <= 1'b0;
      r_er       <= 1'b0;
      r_rxd      <= '0;
      r_smp_ok   <= 1'b0;
      r_armed    <= 1'b0;
      r_n        <= '0;
      r_sr       <= '0;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_good     <= 1'b0;
      r_len      <= '0;
      r_cnt_good <= '0;
      r_cnt_bad  <= '0;
    end else begin
      r_dv     <= bus.gmii_rx_dv;
      r_er     <= bus.gmii_rx_er;
      r_rxd    <= bus.gmii_rxd;
      r_smp_ok <= 1'b1;
      // A frame is only accepted once dv has been seen low after reset, so a
      // frame cut by reset is never picked up in the middle.
      if (r_smp_ok && !r_dv) r_armed <= 1'b1;

      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_good  <= 1'b0;
      r_len   <= '0;

      case (r_state)
        S_IDLE: begin
          if (r_dv) begin
            if (r_armed && r_rxd == 8'h55) begin
              r_state <= S_PRE;
              r_err   <= 1'b0;
            end else begin
              r_state <= S_DROP;
            end
          end
        end

        S_PRE: begin
          if (!r_dv) begin
            r_state <= S_IDLE;
          end else begin
            if (r_er) r_err <= 1'b1;
            if (r_rxd == 8'hD5) begin
              r_state <= S_DATA;
              r_n     <= '0;
            end else if (r_rxd != 8'h55) begin
              r_state <= S_DROP;
            end
          end
        end

        S_DATA: begin
          if (r_dv) begin
            if (r_er) r_err <= 1'b1;
            r_sr <= {r_sr[3:0], r_rxd};
            if (r_n > N_MAX) begin
              // Overlength: close the stream on this beat, drop the rest.
              r_valid   <= 1'b1;
              r_data    <= r_sr[4];
              r_last    <= 1'b1;
              r_len     <= LEN_W'(r_n - N_FCS);
              r_cnt_bad <= sat_inc(r_cnt_bad);
              r_state   <= S_DROP;
            end else begin
              r_n <= r_n + 1'b1;
              if (r_n >= N_HOLD) begin
                r_valid <= 1'b1;
                r_data  <= r_sr[4];
                r_first <= (r_n == N_HOLD);
              end
            end
          end else begin
            r_state <= S_IDLE;
            if (r_n >= N_HOLD) begin
              // Oldest held byte is the last payload byte; the other four are FCS.
              r_valid <= 1'b1;
              r_data  <= r_sr[4];
              r_first <= (r_n == N_HOLD);
              r_last  <= 1'b1;
              r_good  <= w_end_good;
              r_len   <= LEN_W'(r_n - N_FCS);
              if (w_end_good) r_cnt_good <= sat_inc(r_cnt_good);
              else            r_cnt_bad  <= sat_inc(r_cnt_bad);
            end else begin
              r_cnt_bad <= sat_inc(r_cnt_bad);
            end
          end
        end

        S_DROP: begin
          if (!r_dv) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_valid  = r_valid;
  assign bus.m_data   = r_data;
  assign bus.m_first  = r_first;
  assign bus.m_last   = r_last;
  assign bus.m_good   = r_good;
  assign bus.m_len    = r_len;
  assign bus.cnt_good = r_cnt_good;
  assign bus.cnt_bad  = r_cnt_bad;

endmodule

// File: tb/tb_gmii_rx_frame.sv
`timescale 1ns/1ps
module tb_gmii_rx_frame;
  localparam int MIN_F = 13;
  localparam int MAX_F = 1518;
  localparam int LEN_W = 11;
`ifdef GMII_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  gmii_rx_frame_if #(.LEN_W(LEN_W)) bus();
  gmii_rx_frame #(.MIN_FRAME(MIN_F), .MAX_FRAME(MAX_F), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0]  data;
    logic        first;
    logic        last;
    logic        good;
    logic [31:0] len;
  } beat_t;
  typedef struct {
    string name;
    int    n;
    int    npre;
    bit    sfd;
    bit    aa_first;
    int    flip;
    int    er;
    int    exp_beats;
    bit    good_crc;
    bit    good_nocrc;
  } vec_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int checks = 0;
  int failures = 0;
  int mdl_good = 0;
  int mdl_bad = 0;

  always @(negedge clk) begin
    if (bus.m_valid === 1'b1) begin
      beat_t b;
      b.data = bus.m_data; b.first = bus.m_first; b.last = bus.m_last;
      b.good = bus.m_good; b.len = 32'(bus.m_len);
      obs_q.push_back(b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc32(input byte_q_t q, input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Payload bytes 0,1,2.. followed by a correct FCS (LSB first), truncated to n.
  function automatic byte_q_t build_frame(input int n, input int flip);
    byte_q_t q;
    logic [31:0] f;
    int p;
    p = (n >= 4) ? n - 4 : 0;
    for (int i = 0; i < p; i++) q.push_back(8'(i));
    f = crc32(q, p);
    for (int i = 0; i < 4 && q.size() < n; i++) q.push_back(f[8*i +: 8]);
    if (flip >= 0) q[flip] = q[flip] ^ 8'h01;
    return q;
  endfunction

  // Expected behaviour of one properly framed frame (bytes after SFD).
  task automatic model_frame(input byte_q_t q, input int er_idx);
    int n, p;
    bit good;
    beat_t b;
    n = q.size();
    if (n <= 4) begin
      mdl_bad++;
      return;
    end
    p = ((n < MAX_F + 1) ? n : MAX_F + 1) - 4;
    good = (n >= MIN_F) && (n <= MAX_F) && !(er_idx >= 0 && er_idx < n);
    if (CRC_EN && crc32(q, n - 4) != {q[n-1], q[n-2], q[n-3], q[n-4]}) good = 1'b0;
    for (int i = 0; i < p; i++) begin
      b.data = q[i]; b.first = (i == 0); b.last = (i == p - 1);
      b.good = (i == p - 1) ? good : 1'b0;
      b.len  = (i == p - 1) ? 32'(p) : 32'd0;
      exp_q.push_back(b);
    end
    if (good) mdl_good++;
    else      mdl_bad++;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    bus.gmii_rx_dv = dv; bus.gmii_rx_er = er; bus.gmii_rxd = d;
  endtask

  // Gap cycles carry rx_er with dv low, which the deframer must ignore.
  task automatic send(input byte_q_t q, input int npre, input bit sfd, input int er_idx, input int gap);
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
    if (sfd) drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < q.size(); i++) drive(1'b1, (i == er_idx), q[i]);
    for (int i = 0; i < gap; i++) drive(1'b0, 1'b1, 8'h0F);
  endtask

  task automatic flush_check(input string name);
    int bad_i;
    beat_t o, e;
    repeat (10) @(negedge clk);
    bad_i = -1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s beats: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        if (bad_i < 0) begin
          o = obs_q[i]; e = exp_q[i];
          if (o.data !== e.data || o.first !== e.first || o.last !== e.last ||
              (e.last && (o.good !== e.good || o.len !== e.len))) bad_i = i;
        end
      end
      if (bad_i >= 0) begin
        failures++;
        o = obs_q[bad_i]; e = exp_q[bad_i];
        $display("FAIL %s beat %0d: got d=%02h f=%0b l=%0b g=%0b len=%0d expected d=%02h f=%0b l=%0b g=%0b len=%0d",
                 name, bad_i, o.data, o.first, o.last, o.good, o.len, e.data, e.first, e.last, e.good, e.len);
      end
    end
    chk({name, " cnt_good"}, 32'(bus.cnt_good), 32'(mdl_good));
    chk({name, " cnt_bad"}, 32'(bus.cnt_bad), 32'(mdl_bad));
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic vec_t mk(input string name, input int n, input int npre, input bit sfd, input bit aa,
                              input int flip, input int er, input int beats, input bit gc, input bit gn);
    vec_t v;
    v.name = name; v.n = n; v.npre = npre; v.sfd = sfd; v.aa_first = aa; v.flip = flip; v.er = er;
    v.exp_beats = beats; v.good_crc = gc; v.good_nocrc = gn;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    byte_q_t q;
    int kind, n, flip, er, npre, gap;
    logic [31:0] lg;

    tbl.push_back(mk("basic64",  64,   7, 1, 0, -1, -1,   60, 1, 1));
    tbl.push_back(mk("flip10",   64,   7, 1, 0, 10, -1,   60, 0, 1));
    tbl.push_back(mk("er20",     64,   7, 1, 0, -1, 20,   60, 0, 0));
    tbl.push_back(mk("runt3",     3,   1, 1, 0, -1, -1,    0, 0, 0));
    tbl.push_back(mk("runt4",     4,   2, 1, 0, -1, -1,    0, 0, 0));
    tbl.push_back(mk("n5",        5,   1, 1, 0, -1, -1,    1, 0, 0));
    tbl.push_back(mk("short12",  12,   3, 1, 0, -1, -1,    8, 0, 0));
    tbl.push_back(mk("min13",    13,   1, 1, 0, -1, -1,    9, 1, 1));
    tbl.push_back(mk("max1518", 1518,  7, 1, 0, -1, -1, 1514, 1, 1));
    tbl.push_back(mk("over1519",1519,  7, 1, 0, -1, -1, 1515, 0, 0));
    tbl.push_back(mk("over1600",1600,  7, 1, 0, -1, -1, 1515, 0, 0));
    tbl.push_back(mk("aa_first", 64,   0, 0, 1, -1, -1,    0, 0, 0));
    tbl.push_back(mk("pre_only",  0,   5, 0, 0, -1, -1,    0, 0, 0));
    tbl.push_back(mk("bad_sfd",  20,   3, 0, 0, -1, -1,    0, 0, 0));

    rst = 1'b1;
    bus.gmii_rx_dv = 1'b0; bus.gmii_rx_er = 1'b0; bus.gmii_rxd = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst m_first", 32'(bus.m_first), 32'd0);
    chk("rst m_last", 32'(bus.m_last), 32'd0);
    chk("rst m_good", 32'(bus.m_good), 32'd0);
    chk("rst m_len", 32'(bus.m_len), 32'd0);
    chk("rst m_data", 32'(bus.m_data), 32'd0);
    chk("rst cnt_good", 32'(bus.cnt_good), 32'd0);
    chk("rst cnt_bad", 32'(bus.cnt_bad), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < tbl.size(); v++) begin
      q = build_frame(tbl[v].n, tbl[v].flip);
      if (tbl[v].aa_first) q[0] = 8'hAA;
      if (tbl[v].sfd) model_frame(q, tbl[v].er);
      send(q, tbl[v].npre, tbl[v].sfd, tbl[v].er, 2);
      repeat (6) @(negedge clk);
      chk({tbl[v].name, " nbeats"}, 32'(obs_q.size()), 32'(tbl[v].exp_beats));
      if (tbl[v].exp_beats > 0) begin
        lg = (obs_q.size() > 0) ? 32'(obs_q[$].good) : 32'hFFFF_FFFF;
        chk({tbl[v].name, " good"}, lg, CRC_EN ? 32'(tbl[v].good_crc) : 32'(tbl[v].good_nocrc));
      end
      flush_check(tbl[v].name);
    end

    // Known check value: CRC-32 of "123456789" is CBF43926.
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
    model_frame(q, -1);
    send(q, 1, 1'b1, -1, 2);
    repeat (6) @(negedge clk);
    chk("ascii nbeats", 32'(obs_q.size()), 32'd9);
    chk("ascii first byte", (obs_q.size() > 0) ? 32'(obs_q[0].data) : 32'hFFFF_FFFF, 32'h31);
    chk("ascii last byte", (obs_q.size() > 0) ? 32'(obs_q[$].data) : 32'hFFFF_FFFF, 32'h39);
    chk("ascii m_len", (obs_q.size() > 0) ? obs_q[$].len : 32'hFFFF_FFFF, 32'd9);
    chk("ascii m_good", (obs_q.size() > 0) ? 32'(obs_q[$].good) : 32'hFFFF_FFFF, 32'd1);
    flush_check("ascii");

    // Back-to-back frames with a single idle cycle.
    q = build_frame(64, -1);
    model_frame(q, -1);
    send(q, 7, 1'b1, -1, 1);
    q = build_frame(70, -1);
    model_frame(q, -1);
    send(q, 7, 1'b1, -1, 2);
    flush_check("b2b");

    // Randomized stream: good, corrupted, errored, runt, aborted and misframed.
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 9);
      n    = $urandom_range(1, 80);
      flip = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      er   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      npre = $urandom_range(1, 7);
      gap  = $urandom_range(1, 3);
      q = build_frame(n, flip);
      if (kind == 0) begin
        q[0] = 8'hAA;
        send(q, 0, 1'b0, er, gap);
      end else if (kind == 1) begin
        q.delete();
        send(q, npre, 1'b0, -1, gap);
      end else begin
        model_frame(q, er);
        send(q, npre, 1'b1, er, gap);
      end
    end
    flush_check("random");

    // Reset in the middle of a frame.
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 8'(i));
    chk("rst_mid streaming", 32'(bus.m_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_mid cnt_good", 32'(bus.cnt_good), 32'd0);
    obs_q.delete(); exp_q.delete();
    mdl_good = 0; mdl_bad = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h40 + 8'(i));
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
    flush_check("rst_drop");

    q = build_frame(64, -1);
    model_frame(q, -1);
    send(q, 7, 1'b1, -1, 2);
    flush_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
